// File: rtl/tamagotchi_needs_if.sv
// tamagotchi_needs_if: button/display bundle between the pet front-end and the needs core
// Ports: btn_care/btn_test/decay_inhibit (front-end -> core); sel, level_out, happy,
// seg_display, mood, alarm, test_mode (core -> display). master = front-end, slave = core.
interface tamagotchi_needs_if #(
    parameter int N_NEEDS = 4,
    parameter int LVL_W   = 4
);
    logic [N_NEEDS-1:0] btn_care;
    logic               btn_test;
    logic [N_NEEDS-1:0] decay_inhibit;
    logic [2:0]         sel;
    logic [LVL_W-1:0]   level_out;
    logic               happy;
    logic [6:0]         seg_display;
    logic [1:0]         mood;
    logic [N_NEEDS-1:0] alarm;
    logic               test_mode;
    modport master (
        output btn_care, btn_test, decay_inhibit,
        input  sel, level_out, happy, seg_display, mood, alarm, test_mode
    );
    modport slave (
        input  btn_care, btn_test, decay_inhibit,
        output sel, level_out, happy, seg_display, mood, alarm, test_mode
    );
endinterface

// File: rtl/tamagotchi_needs_core.sv
// tamagotchi_needs_core: N-need level tracker with prescaled decay, care buttons, test mode and mood summary
// Ports: clk, btn_reset (sync, active-high); bus (slave) carries care/test/inhibit inputs
// and the registered sel, level_out, happy, seg_display, mood, alarm, test_mode outputs.
module tamagotchi_needs_core #(
    parameter int                       N_NEEDS       = 4,
    parameter int                       LVL_W         = 4,
    parameter int                       LVL_MAX       = 10,
    parameter int                       LVL_INIT      = 8,
    parameter int                       CARE_STEP     = 1,
    parameter int                       HAPPY_THR     = 5,
    parameter int                       TICK_DIV      = 50_000_000,
    parameter logic [8*N_NEEDS-1:0]     DECAY_PERIODS = {8'd50, 8'd70, 8'd100, 8'd120}
) (
    input logic               clk,
    input logic               btn_reset,
    tamagotchi_needs_if.slave bus
);
    localparam int IW = N_NEEDS > 1 ? $clog2(N_NEEDS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    logic [LVL_W-1:0]   lvl_q [N_NEEDS];
    logic [LVL_W-1:0]   lvl_d [N_NEEDS];
    logic [7:0]         cnt_q [N_NEEDS];
    logic [7:0]         cnt_d [N_NEEDS];
    logic [8:0]         cnt_nxt [N_NEEDS];
    logic [LVL_W:0]     base [N_NEEDS];
    logic [LVL_W:0]     sum [N_NEEDS];
    logic [N_NEEDS-1:0] dec, adv, care_me, low;
    logic [PW-1:0]      pre_q, pre_d;
    logic [N_NEEDS-1:0] care_prev_q, care_prev_d, care_rise;
    logic               test_prev_q, test_prev_d, test_tgl, care_hit, tick;
    logic [2:0]         care_idx, sel_q, sel_d;
    logic               test_q, test_d;
    logic [2:0]         sel_o_q, sel_o_d;
    logic [LVL_W-1:0]   lvl_o_q, lvl_o_d;
    logic               happy_q, happy_d, test_o_q, test_o_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         mood_q, mood_d;
    logic [N_NEEDS-1:0] alarm_q, alarm_d;

    function automatic logic [6:0] seg7(input logic [LVL_W-1:0] v);
        case (32'(v))
            0:       seg7 = 7'b0111111;
            1:       seg7 = 7'b0000110;
            2:       seg7 = 7'b1011011;
            3:       seg7 = 7'b1001111;
            4:       seg7 = 7'b1100110;
            5:       seg7 = 7'b1101101;
            6:       seg7 = 7'b1111101;
            7:       seg7 = 7'b0000111;
            8:       seg7 = 7'b1111111;
            9:       seg7 = 7'b1101111;
            10:      seg7 = 7'b1110111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        care_prev_d = bus.btn_care;
        test_prev_d = bus.btn_test;
        care_rise   = bus.btn_care & ~care_prev_q;
        care_hit    = |care_rise;
        care_idx    = '0;
        // descending scan so the lowest rising index is the one that sticks
        for (int i = N_NEEDS - 1; i >= 0; i--) if (care_rise[i]) care_idx = 3'(i);
        test_tgl = bus.btn_test & ~test_prev_q;
        test_d   = test_q ^ test_tgl;
        tick     = !test_q && pre_q == PW'(TICK_DIV - 1);
        pre_d    = (test_tgl || tick) ? '0 : test_q ? pre_q : pre_q + PW'(1);
        sel_d    = care_hit ? care_idx : sel_q;
        for (int i = 0; i < N_NEEDS; i++) begin
            cnt_nxt[i] = {1'b0, cnt_q[i]} + 9'd1;
            adv[i]     = tick && !bus.decay_inhibit[i];
            dec[i]     = adv[i] && !test_tgl && cnt_nxt[i] == 9'(DECAY_PERIODS[8*i +: 8]);
            cnt_d[i]   = test_tgl ? '0 : !adv[i] ? cnt_q[i] : dec[i] ? '0 : cnt_nxt[i][7:0];
            base[i]    = !dec[i] ? {1'b0, lvl_q[i]} : lvl_q[i] == '0 ? '0 : {1'b0, lvl_q[i]} - (LVL_W+1)'(1);
            sum[i]     = base[i] + (LVL_W+1)'(CARE_STEP);
            care_me[i] = care_hit && care_idx == sel_q && care_idx == 3'(i);
            lvl_d[i]   = !care_me[i] ? base[i][LVL_W-1:0] :
                         test_q ? (lvl_q[i] == LVL_W'(1) ? LVL_W'(LVL_MAX) : LVL_W'(1)) :
                         sum[i] > (LVL_W+1)'(LVL_MAX) ? LVL_W'(LVL_MAX) : sum[i][LVL_W-1:0];
            alarm_d[i] = lvl_q[i] == '0;
            low[i]     = lvl_q[i] < LVL_W'(HAPPY_THR);
        end
        sel_o_d  = sel_q;
        lvl_o_d  = lvl_q[sel_q[IW-1:0]];
        happy_d  = lvl_o_d >= LVL_W'(HAPPY_THR);
        seg_d    = seg7(lvl_o_d);
        mood_d   = |alarm_d ? 2'b10 : |low ? 2'b01 : 2'b00;
        test_o_d = test_q;
    end

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            for (int i = 0; i < N_NEEDS; i++) begin
                lvl_q[i] <= LVL_W'(LVL_INIT);
                cnt_q[i] <= '0;
            end
            pre_q       <= '0;
            care_prev_q <= '0;
            test_prev_q <= 1'b0;
            sel_q       <= '0;
            test_q      <= 1'b0;
        end else begin
            for (int i = 0; i < N_NEEDS; i++) begin
                lvl_q[i] <= lvl_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pre_q       <= pre_d;
            care_prev_q <= care_prev_d;
            test_prev_q <= test_prev_d;
            sel_q       <= sel_d;
            test_q      <= test_d;
        end
    end

    // output stage always mirrors the state one cycle later, reset included
    always_ff @(posedge clk) begin
        sel_o_q  <= sel_o_d;
        lvl_o_q  <= lvl_o_d;
        happy_q  <= happy_d;
        seg_q    <= seg_d;
        mood_q   <= mood_d;
        alarm_q  <= alarm_d;
        test_o_q <= test_o_d;
    end

    assign bus.sel         = sel_o_q;
    assign bus.level_out   = lvl_o_q;
    assign bus.happy       = happy_q;
    assign bus.seg_display = seg_q;
    assign bus.mood        = mood_q;
    assign bus.alarm       = alarm_q;
    assign bus.test_mode   = test_o_q;
endmodule

// File: tb/tb_tamagotchi_needs_core.sv
// tb_tamagotchi_needs_core: directed checks of reset, care, decay, inhibit, test mode and collisions
module tb_tamagotchi_needs_core;
    logic clk = 1'b0;
    logic btn_reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t = 0;

    always #5 clk = ~clk;

    tamagotchi_needs_if #(.N_NEEDS(4), .LVL_W(4)) bus ();

    tamagotchi_needs_core #(
        .N_NEEDS(4), .LVL_W(4), .LVL_MAX(10), .LVL_INIT(8), .CARE_STEP(1), .HAPPY_THR(5),
        .TICK_DIV(4), .DECAY_PERIODS({8'd250, 8'd250, 8'd250, 8'd2})
    ) dut (
        .clk(clk),
        .btn_reset(btn_reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic wait_to(input int m);
        cyc(m - t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_reset = 1'b1;
        @(negedge clk);
        btn_reset = 1'b0;
        t = 0;
    endtask

    task automatic care(input logic [3:0] b);
        bus.btn_care = b;
        cyc(1);
        bus.btn_care = '0;
        cyc(1);
    endtask

    task automatic tst();
        bus.btn_test = 1'b1;
        cyc(1);
        bus.btn_test = 1'b0;
        cyc(1);
    endtask

    initial begin
        bus.btn_care      = '0;
        bus.btn_test      = 1'b0;
        bus.decay_inhibit = 4'b1111;
        // reset values and select/care with decay frozen
        do_reset();
        cyc(1);
        chk("rst_level", 32'(bus.level_out), 8);
        chk("rst_seg", 32'(bus.seg_display), 32'h7F);
        chk("rst_happy", 32'(bus.happy), 1);
        chk("rst_mood", 32'(bus.mood), 0);
        chk("rst_alarm", 32'(bus.alarm), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_test", 32'(bus.test_mode), 0);
        care(4'b0100);
        chk("sel2", 32'(bus.sel), 2);
        chk("sel2_level", 32'(bus.level_out), 8);
        care(4'b0100);
        chk("care_9", 32'(bus.level_out), 9);
        care(4'b0100);
        chk("care_10", 32'(bus.level_out), 10);
        care(4'b0100);
        chk("care_sat", 32'(bus.level_out), 10);
        chk("seg_A", 32'(bus.seg_display), 32'h77);
        care(4'b0110);
        chk("multi_sel", 32'(bus.sel), 1);
        chk("multi_level", 32'(bus.level_out), 8);
        bus.btn_care = 4'b0001;
        cyc(5);
        bus.btn_care = '0;
        cyc(1);
        chk("hold_sel", 32'(bus.sel), 0);
        chk("hold_level", 32'(bus.level_out), 8);
        // free-running decay of need 0: one step every 8 cycles
        bus.decay_inhibit = '0;
        do_reset();
        wait_to(8);
        chk("dec_pre", 32'(bus.level_out), 8);
        wait_to(9);
        chk("dec_first", 32'(bus.level_out), 7);
        chk("seg_7", 32'(bus.seg_display), 32'h07);
        wait_to(25);
        chk("dec_5", 32'(bus.level_out), 5);
        chk("happy_5", 32'(bus.happy), 1);
        chk("mood_5", 32'(bus.mood), 0);
        wait_to(33);
        chk("dec_4", 32'(bus.level_out), 4);
        chk("happy_4", 32'(bus.happy), 0);
        chk("mood_4", 32'(bus.mood), 1);
        wait_to(64);
        chk("dec_1", 32'(bus.level_out), 1);
        wait_to(65);
        chk("dec_0", 32'(bus.level_out), 0);
        chk("alarm_0", 32'(bus.alarm), 1);
        chk("mood_0", 32'(bus.mood), 2);
        chk("seg_0", 32'(bus.seg_display), 32'h3F);
        wait_to(90);
        chk("floor_0", 32'(bus.level_out), 0);
        // inhibit pauses counter at 1; resumes so the step lands on edge 56
        do_reset();
        wait_to(13);
        bus.decay_inhibit = 4'b0001;
        wait_to(40);
        chk("inh_hold", 32'(bus.level_out), 7);
        wait_to(53);
        bus.decay_inhibit = '0;
        wait_to(56);
        chk("inh_pre", 32'(bus.level_out), 7);
        wait_to(57);
        chk("inh_resume", 32'(bus.level_out), 6);
        // test mode
        do_reset();
        cyc(1);
        tst();
        chk("tm_on", 32'(bus.test_mode), 1);
        care(4'b0001);
        chk("tm_1", 32'(bus.level_out), 1);
        chk("seg_1", 32'(bus.seg_display), 32'h06);
        care(4'b0001);
        chk("tm_max", 32'(bus.level_out), 10);
        care(4'b0001);
        chk("tm_1b", 32'(bus.level_out), 1);
        wait_to(49);
        chk("tm_halt", 32'(bus.level_out), 1);
        tst();
        chk("tm_off", 32'(bus.test_mode), 0);
        wait_to(58);
        chk("tm_resume_pre", 32'(bus.level_out), 1);
        wait_to(59);
        chk("tm_resume", 32'(bus.level_out), 0);
        chk("tm_alarm", 32'(bus.alarm), 1);
        chk("tm_mood", 32'(bus.mood), 2);
        // care colliding with decay at level 10, then reset mid-decay
        do_reset();
        care(4'b0001);
        care(4'b0001);
        wait_to(7);
        care(4'b0001);
        chk("coll_10", 32'(bus.level_out), 10);
        wait_to(16);
        chk("coll_hold", 32'(bus.level_out), 10);
        wait_to(17);
        chk("coll_next", 32'(bus.level_out), 9);
        wait_to(21);
        do_reset();
        cyc(1);
        chk("mid_rst_level", 32'(bus.level_out), 8);
        wait_to(8);
        chk("mid_rst_pre", 32'(bus.level_out), 8);
        wait_to(9);
        chk("mid_rst_dec", 32'(bus.level_out), 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
